// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: RV32I opcodes, the halt
// sequencer states and the packed decode control bundle.
package id_ex_stage_pkg;

  localparam logic [6:0] OP_JAL        = 7'b1101111;
  localparam logic [6:0] OP_JALR       = 7'b1100111;
  localparam logic [6:0] OP_BRANCH     = 7'b1100011;
  localparam logic [6:0] OP_LOAD       = 7'b0000011;
  localparam logic [6:0] OP_STORE      = 7'b0100011;
  localparam logic [6:0] OP_ARITHMETIC = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM  = 7'b0010011;
  localparam logic [6:0] OP_ECALL      = 7'b1110011;
  localparam logic [6:0] OP_LUI        = 7'b0110111;
  localparam logic [6:0] OP_AUIPC      = 7'b0010111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  typedef struct packed {
    logic is_jal;
    logic is_jalr;
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic write_enable;
    logic pc_to_reg;
    logic is_ecall;
    logic halt_req;
  } ctrl_t;

  // Everything except JAL, LUI and AUIPC reads rs1; an ecall reads x17
  // through its rs1 field, so it is covered here as well.
  function automatic logic reads_rs1(input logic [6:0] opcode);
    return !((opcode == OP_JAL) || (opcode == OP_LUI) || (opcode == OP_AUIPC));
  endfunction

  // Only register-register ALU ops, stores and branches read rs2.
  function automatic logic reads_rs2(input logic [6:0] opcode);
    return (opcode == OP_ARITHMETIC) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the decode slot and the EX slot.
// Purely combinational so a forwarding unit can reuse it later.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic use_rs1;
  logic use_rs2;
  logic rs1_hit;
  logic rs2_hit;

  // A load in EX whose destination is a register the decode instruction reads
  // cannot be forwarded in time; x0 is never a real dependency.
  always_comb begin
    use_rs1  = reads_rs1(id_opcode);
    use_rs2  = reads_rs2(id_opcode);
    rs1_hit  = use_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = use_rs2 && (id_rs2 == ex_rd);
    load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches the decode bundle, inserts bubbles on
// load-use stalls, flushes and halts, and sequences the ecall halt drain.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [6:0]      id_opcode,
  input  logic            id_is_jal,
  input  logic            id_is_jalr,
  input  logic            id_branch,
  input  logic            id_mem_read,
  input  logic            id_mem_to_reg,
  input  logic            id_mem_write,
  input  logic            id_alu_src,
  input  logic            id_write_enable,
  input  logic            id_pc_to_reg,
  input  logic            id_is_ecall,
  input  logic            id_halt_req,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [10:0]     id_alu_ctrl,
  input  logic            ex_flush,
  output logic            ex_valid,
  output logic [6:0]      ex_opcode,
  output logic            ex_is_jal,
  output logic            ex_is_jalr,
  output logic            ex_branch,
  output logic            ex_mem_read,
  output logic            ex_mem_to_reg,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_write_enable,
  output logic            ex_pc_to_reg,
  output logic            ex_is_ecall,
  output logic            ex_halt_req,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [10:0]     ex_alu_ctrl,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            is_halted
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  halt_state_t      state;
  halt_state_t      state_next;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] cnt_next;

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;

  logic load_use;
  logic stall;
  logic bubble;
  logic halt_start;

  assign id_ctrl = '{
    is_jal:       id_is_jal,
    is_jalr:      id_is_jalr,
    branch:       id_branch,
    mem_read:     id_mem_read,
    mem_to_reg:   id_mem_to_reg,
    mem_write:    id_mem_write,
    alu_src:      id_alu_src,
    write_enable: id_write_enable,
    pc_to_reg:    id_pc_to_reg,
    is_ecall:     id_is_ecall,
    halt_req:     id_halt_req
  };

  hazard_detect u_hazard_detect (
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  // Stall and bubble decisions; a flush overrides a load-use stall so the
  // redirect still advances the PC, while any halt state freezes fetch.
  always_comb begin
    stall       = (load_use && !ex_flush) || (state != RUN);
    bubble      = ex_flush || stall;
    pc_write    = !stall;
    if_id_write = !stall;
    halt_start  = ex_valid && ex_ctrl.is_ecall && ex_ctrl.halt_req && !ex_flush;
    is_halted   = (state == HALTED);
  end

  // Halt sequencer state and drain counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= cnt_next;
    end
  end

  // Halt sequencer next state: a surviving halting ecall in EX starts a drain
  // that lets older instructions retire before the core reports halted.
  always_comb begin
    state_next = state;
    cnt_next   = drain_cnt;
    case (state)
      RUN: begin
        if (halt_start) begin
          state_next = DRAIN;
          cnt_next   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_next = HALTED;
        end else begin
          cnt_next = drain_cnt - CNT_W'(1);
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // The pipeline register itself; bubbles clear validity and every control
  // bit, while data fields simply follow decode since EX ignores them then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_opcode   <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_alu_ctrl <= '0;
    end else begin
      ex_valid    <= bubble ? 1'b0 : id_valid;
      ex_ctrl     <= bubble ? '0 : id_ctrl;
      ex_opcode   <= id_opcode;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_alu_ctrl <= id_alu_ctrl;
    end
  end

  assign ex_is_jal       = ex_ctrl.is_jal;
  assign ex_is_jalr      = ex_ctrl.is_jalr;
  assign ex_branch       = ex_ctrl.branch;
  assign ex_mem_read     = ex_ctrl.mem_read;
  assign ex_mem_to_reg   = ex_ctrl.mem_to_reg;
  assign ex_mem_write    = ex_ctrl.mem_write;
  assign ex_alu_src      = ex_ctrl.alu_src;
  assign ex_write_enable = ex_ctrl.write_enable;
  assign ex_pc_to_reg    = ex_ctrl.pc_to_reg;
  assign ex_is_ecall     = ex_ctrl.is_ecall;
  assign ex_halt_req     = ex_ctrl.halt_req;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute in the pipelined RV32I core. It latches the decode-stage control bundle, operands and register indices, and detects load-use hazards. It inserts a bubble on a load-use stall or a control-flow flush, and runs the ecall halt drain sequence that raises the core's halted flag.

## Interface
Parameters:
- XLEN, 32, datapath width
- DRAIN_CYCLES, 2, cycles after a halting ecall leaves EX before is_halted rises

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- id_valid  in  1  decode slot holds a real instruction
- id_opcode  in  7  inst[6:0]
- id_is_jal, id_is_jalr, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_write_enable, id_pc_to_reg, id_is_ecall  in  1 each  decode control bundle
- id_halt_req  in  1  ecall with x17 == 10, after forwarding
- id_pc  in  XLEN  decode PC
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  operands and immediate
- id_rs1, id_rs2, id_rd  in  5  register indices; for ecall, id_rs1 = 17
- id_alu_ctrl  in  11  {inst[30], inst[14:12], inst[6:0]}
- ex_flush  in  1  redirect from EX (taken branch or jump)
- ex_* (same names with ex_ prefix)  out  as above  registered bundle to EX
- ex_valid  out  1  EX slot is real
- pc_write  out  1  PC may advance
- if_id_write  out  1  IF/ID register may load
- is_halted  out  1  core halted; sticky until reset

## Operation
- use_rs1 = opcode not in {JAL, LUI, AUIPC}. use_rs2 = opcode in {ARITHMETIC, STORE, BRANCH}. Ecall counts as a use_rs1 of x17.
- load_use = id_valid & ex_valid & ex_mem_read & ex_rd != 0 & ((use_rs1 & id_rs1 == ex_rd) | (use_rs2 & id_rs2 == ex_rd)).
- stall = (load_use & !ex_flush) | state != RUN. pc_write = if_id_write = !stall.
- Next register content, by priority:
  - ex_flush, stall, or state != RUN: bubble.
  - Otherwise: the id_* values, with ex_valid = id_valid.
- Bubble: ex_valid = 0 and all control bits 0. Data fields may hold don't-care values; the bench checks them only when ex_valid = 1.
- Halt FSM:
  - RUN -> DRAIN when the EX slot holds valid & is_ecall & halt_req and ex_flush = 0. drain_cnt loads DRAIN_CYCLES-1.
  - DRAIN: drain_cnt decrements each cycle. At 0, go to HALTED.
  - HALTED: absorbing. is_halted = 1.
- A halting ecall killed by ex_flush in the same cycle does not start the drain.

## Timing
- Reset (async assert): ex_valid = 0, all ex_* = 0, state = RUN, drain_cnt = 0, is_halted = 0.
- Combinational outputs while in reset: pc_write = if_id_write = 1.
- Latency: one cycle, id_* to ex_*.
- stall and pc_write/if_id_write are combinational in the same cycle as the hazard.
- A load-use stall lasts exactly 1 cycle, because the bubble clears the hazard.
- Flush and load_use in the same cycle: flush wins; pc_write = 1 so the redirect takes.
- Halt: with the ecall in EX at cycle t, is_halted rises at the edge ending cycle t+DRAIN_CYCLES.
- From t+1 onward: pc_write = 0 and bubbles are inserted.
- Reset asserted mid-DRAIN returns to RUN immediately.

## Structure
- Shared package or opcodes.v supplies the opcode constants (JAL, JALR, BRANCH, LOAD, STORE, ARITHMETIC, ECALL, LUI, AUIPC) and a halt state enum {RUN, DRAIN, HALTED}.
- One natural sub-module: hazard_detect, the combinational load_use and use_rs logic, reusable by a later forwarding unit.

## Test plan
- Load-use: lw x5 in EX, add x6,x5,x7 in ID -> stall for 1 cycle, then ex_valid = 0 bubble, then the add enters EX with pc_write = 1.
- x0 load: lw x0 followed by add x1,x0,x0 -> no stall.
- Non-use: lw x5 followed by jal x1 -> no stall.
- Flush priority: ex_flush = 1 together with load_use -> bubble, pc_write = 1.
- Halt: ecall with halt_req = 1 enters EX -> pc_write = 0 from the next cycle, is_halted = 1 after 2 cycles, sticky.
- Flushed ecall: same ecall with ex_flush = 1 in its EX cycle -> no halt.
- Reset mid-operation: reset low during DRAIN -> all ex_* = 0 and is_halted = 0 asynchronously; normal flow resumes on release.
